// File: rtl/sub_word_seq.sv
// sub_word_seq: sequential AES SubWord engine.
// Takes one WORD per valid/ready handshake. LANES S-box instances are
// time-shared over STEPS = (WORD/BYTE)/LANES cycles, and the bytes are
// substituted in place in a work register.
// Optional feature macro: SUBWORD_INV_EN adds an inv port and inverse S-box
// tables. The mode is latched at accept and applies to the whole word.
module sub_word_seq #(
   parameter int BYTE  = 8,
   parameter int WORD  = 32,
   parameter int LANES = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [WORD-1:0] in_word,
`ifdef SUBWORD_INV_EN
   input  logic            inv,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [WORD-1:0] out_word
);

   localparam int NBYTES = WORD / BYTE;
   localparam int STEPS  = NBYTES / LANES;
   localparam int CW     = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   // FIPS-197 forward S-box, indexed by the input byte.
   localparam logic [7:0] SBOX_FWD [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

`ifdef SUBWORD_INV_EN
   // FIPS-197 inverse S-box (InvSubBytes), indexed by the input byte.
   localparam logic [7:0] SBOX_INV [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d
   };
   logic mode;
`endif

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [WORD-1:0] work, sub_word;
   logic [BYTE-1:0] lane_in  [LANES];
   logic [BYTE-1:0] lane_out [LANES];

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign out_word  = work;

   // Route the current group of bytes to the shared lanes and look them up.
   always_comb begin
      for (int l = 0; l < LANES; l++) begin
         lane_in[l] = work[(int'(cnt) * LANES + l) * BYTE +: BYTE];
`ifdef SUBWORD_INV_EN
         lane_out[l] = mode ? SBOX_INV[lane_in[l]] : SBOX_FWD[lane_in[l]];
`else
         lane_out[l] = SBOX_FWD[lane_in[l]];
`endif
      end
   end

   // Write the lane results back in place; every other byte holds.
   always_comb begin
      // NOTE: default first so every path assigns the whole word and no latch is inferred.
      sub_word = work;
      for (int i = 0; i < NBYTES; i++) begin
         if (CW'(i / LANES) == cnt) sub_word[i*BYTE +: BYTE] = lane_out[i % LANES];
      end
   end

   // Next-state decode for the handshake FSM.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)    state_nxt = BUSY;
         BUSY:    if (cnt == LAST) state_nxt = DONE;
         DONE:    if (out_ready)   state_nxt = IDLE;
         default:                  state_nxt = IDLE;
      endcase
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: reset is sampled on the clock edge only, and state uses <= so all flops update together.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Datapath: load on accept, substitute one group per BUSY cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         work <= '0;
`ifdef SUBWORD_INV_EN
         mode <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               work <= in_word;
               cnt  <= '0;
`ifdef SUBWORD_INV_EN
               mode <= inv;
`endif
            end
            BUSY: begin
               work <= sub_word;
               if (cnt != LAST) cnt <= cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/sub_word_seq.md
Name: sub_word_seq

Overview:
Sequential, parametrised SubWord engine for the AES key-expansion and round datapath. It accepts one WORD per valid/ready handshake and substitutes each BYTE through the AES S-box. LANES S-box instances are time-shared, so the engineer trades area against latency with one parameter. Sits between the key-schedule controller and the round-key register file, and also serves the SubBytes column path.

Parameters:
BYTE, 8, bits per S-box symbol; only 8 is supported.
WORD, 32, bits per word; must be a multiple of BYTE.
LANES, 1, S-box instances used per cycle; must divide NBYTES = WORD/BYTE.
(derived, local) NBYTES = WORD/BYTE; STEPS = NBYTES/LANES; CW = max(1, clog2(STEPS)).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk
in_valid  input  1  in_word (and inv) present
in_ready  output  1  block can accept a word
in_word  input  WORD  word to substitute; byte i = in_word[(i+1)*BYTE-1 : i*BYTE]
inv  input  1  present only with SUBWORD_INV_EN; 1 selects the inverse S-box
out_valid  output  1  out_word holds the finished result
out_ready  input  1  consumer accepts out_word
out_word  output  WORD  substituted word, same byte ordering as in_word

Behaviour:
- Clocking: one clock, clk. Reset is synchronous and active-low on rst_n. All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- FSM states: IDLE, BUSY, DONE.
- in_ready = (state == IDLE). out_valid = (state == DONE).
- Reset (rst_n = 0 at an edge): state becomes IDLE, step counter 0, work register 0, mode register 0. After reset: out_valid 0, out_word 0, in_ready 1.
- IDLE: on in_valid && in_ready, load the work register with in_word, latch inv (or 0), clear the counter, and go to BUSY. Otherwise hold.
- BUSY, step c:
  - Bytes c*LANES through c*LANES+LANES-1 of the work register pass through the lanes and are written back in place. All other bytes hold.
  - If c == STEPS-1, go to DONE. Otherwise c increments.
- DONE: out_word = work register. It stays stable while out_valid=1 && out_ready=0. On out_ready, go to IDLE.
- No accept occurs in the DONE cycle. Throughput is one word per STEPS+2 cycles.
- Latency: a handshake at edge k gives out_valid=1 after edge k+STEPS. Example: LANES=1, WORD=32 → 4 cycles; LANES=4 → 1 cycle.
- In BUSY or DONE, in_valid is ignored and no state changes from it. in_word and inv are sampled only at the accept edge.
- out_ready while not in DONE is ignored.
- out_word outside DONE shows the work register. Consumers qualify it with out_valid only.
- Reset mid-operation: the word in flight is discarded. out_valid is 0 and in_ready is 1 after that edge.
- S-box: combinational 256-entry FIPS-197 forward table, one instance per lane. The mapping is bit-identical to the team's existing Sbox.
- Counter wrap: the counter never exceeds STEPS-1. With STEPS=1 the counter stays 0.

Optional Feature:
SUBWORD_INV_EN
- Defined: the inv port exists. Each lane instantiates both the forward and the inverse S-box (FIPS-197 InvSubBytes table). A mode bit, latched at accept, selects the output for the whole word.
- Not defined: there is no inv port and no inverse tables; forward only. Timing and handshake are identical in both builds.

Test Plan:
- Reset then idle: hold rst_n=0 for 2 edges, then release → in_ready=1, out_valid=0, out_word=0; no change without in_valid.
- Basic forward, LANES=1: in_word=0x00010253 accepted at edge k → out_valid=1 from edge k+4, out_word=0x637c77ed.
- FIPS-197 key-expansion vector, LANES=4: in_word=0xcf4f3c09 → out_word=0x8a84eb01 one cycle after accept. Then LANES=2 → same value after 2 cycles.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_word stable at 0x637c77ed, in_ready=0. Pulse in_valid with 0xffffffff during the stall → ignored. Raise out_ready → IDLE next cycle.
- Reset mid-BUSY: accept 0x00010253 (LANES=1), assert rst_n=0 at step 2 → out_valid=0, in_ready=1, out_word=0 next cycle; no output is produced.
- With SUBWORD_INV_EN: inv=1, in_word=0x637c77ed → out_word=0x00010253. Then inv=0, in_word=0xffffffff → 0x16161616.
